ringosc_freq_meter_ctrl: RTL and testbench

Sequencer for the 5-inverter ring oscillator and its 16-stage ripple divider.
- Resets the divider, enables the ring, waits for it to settle, and opens a gate window of programmable length in the clk domain.
- Counts rising edges of one selected divider tap and latches the result.
- Sits between the top-level pin mux and the oscillator/divider instance. It drives the ring enable and divider reset. It consumes one divider tap as an asynchronous input.

---
 rtl/ringosc_freq_meter_ctrl_if.sv | 23 ++
 rtl/ringosc_freq_meter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ringosc_freq_meter_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ringosc_freq_meter_ctrl_if.sv
// Control/result bundle between the pin mux (master) and the ring-oscillator
// frequency meter sequencer (slave).
interface ringosc_freq_meter_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               start;
  logic               abort;
  logic [3:0]         gate_sel;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] result;
  logic               overflow;

  modport master (
    output start, abort, gate_sel,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, abort, gate_sel,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/ringosc_freq_meter_ctrl.sv
// Ring-oscillator frequency meter sequencer: divider reset, ring settle, gated
// edge count of one divider tap. Define RINGOSC_CONT_MEAS_EN for back-to-back measurement.
//
// state  | meaning
// IDLE   | ring off, divider out of reset, waiting for start
// DRST   | divider held in reset, ring off
// SETTLE | ring running, edges ignored
// GATE   | ring running, edges counted for 2^gate_sel cycles
// DRAIN  | count edges still in the synchroniser pipeline
// DONE   | latch result/overflow, pulse done
module ringosc_freq_meter_ctrl #(
  parameter int COUNT_W        = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DIV_RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ringosc_freq_meter_ctrl_if.slave   bus,
  input  logic                       ro_tap_i,
  output logic                       ro_en_o,
  output logic                       ro_rst_n_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRST   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_GATE   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [15:0]        DRST_LOAD   = 16'(DIV_RST_CYCLES - 1);
  localparam logic [15:0]        SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

`ifdef RINGOSC_CONT_MEAS_EN
  localparam logic CONT_EN = 1'b1;
`else
  localparam logic CONT_EN = 1'b0;
`endif

  logic [2:0]         state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [3:0]         gsel_q, gsel_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               ro_en_q, ro_en_d;
  logic               ro_rst_n_q, ro_rst_n_d;
  logic               s1_q, s2_q, s3_q;
  logic               edge_pulse;
  logic               tc;
  logic [15:0]        gate_load;

  assign edge_pulse = s2_q & ~s3_q;
  assign tc         = (timer_q == 16'd0);
  assign gate_load  = (16'd1 << gsel_q) - 16'd1;

  always_comb begin
    state_d   = state_q;
    timer_d   = tc ? timer_q : timer_q - 16'd1;
    gsel_d    = gsel_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    // DRAIN still counts: those pulses come from samples taken inside the gate
    if ((state_q == S_GATE || state_q == S_DRAIN) && edge_pulse) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_MAX - 1'b1) ovf_acc_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_DRST;
          timer_d   = DRST_LOAD;
          gsel_d    = bus.gate_sel;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end
      end
      S_DRST: begin
        if (tc) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (tc) begin
          state_d = S_GATE;
          timer_d = gate_load;
        end
      end
      S_GATE: begin
        if (tc) begin
          state_d = S_DRAIN;
          timer_d = 16'd1;
        end
      end
      S_DRAIN: begin
        if (tc) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = cnt_q;
        ovf_d    = ovf_acc_q;
        done_d   = 1'b1;
        if (CONT_EN && bus.start) begin
          state_d   = S_SETTLE;
          timer_d   = SETTLE_LOAD;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d  = S_IDLE;
      result_d = result_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
    end

    // Pin drives are registered from the next state so they never glitch
    ro_en_d    = (state_d == S_SETTLE) || (state_d == S_GATE) ||
                 (CONT_EN && (state_d == S_DRAIN || state_d == S_DONE));
    ro_rst_n_d = (state_d != S_DRST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      gsel_q     <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      ro_en_q    <= 1'b0;
      ro_rst_n_q <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gsel_q     <= gsel_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      ro_en_q    <= ro_en_d;
      ro_rst_n_q <= ro_rst_n_d;
      s1_q       <= ro_tap_i;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign ro_en_o      = ro_en_q;
  assign ro_rst_n_o   = ro_rst_n_q;

endmodule

// File: tb/tb_ringosc_freq_meter_ctrl.sv
// Scoreboard bench for ringosc_freq_meter_ctrl; a 12-bit instance covers overflow.
module tb_ringosc_freq_meter_ctrl;

  typedef struct {
    int   lo;
    int   hi;
    logic ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ro_tap;
  int   tap_half;
  int   tests_run;
  int   tests_failed;
  exp_t sbq[$];

  logic ro_en16, ro_rst_n16, ro_en12, ro_rst_n12;

  ringosc_freq_meter_ctrl_if #(.COUNT_W(16)) bus16 ();
  ringosc_freq_meter_ctrl_if #(.COUNT_W(12)) bus12 ();

  ringosc_freq_meter_ctrl #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus16),
    .ro_tap_i(ro_tap), .ro_en_o(ro_en16), .ro_rst_n_o(ro_rst_n16)
  );

  ringosc_freq_meter_ctrl #(.COUNT_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .bus(bus12),
    .ro_tap_i(ro_tap), .ro_en_o(ro_en12), .ro_rst_n_o(ro_rst_n12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider tap model: toggles every tap_half clk cycles, away from the clock edge
  initial begin
    ro_tap = 1'b0;
    forever begin
      if (tap_half == 0) begin
        @(posedge clk);
        #3 ro_tap = 1'b0;
      end else begin
        repeat (tap_half) @(posedge clk);
        #3 ro_tap = ~ro_tap;
      end
    end
  end

  task automatic launch16(input logic [3:0] g);
    @(posedge clk);
    #1 bus16.gate_sel = g;
    bus16.start = 1'b1;
    @(posedge clk);
    #1 bus16.start = 1'b0;
    bus16.gate_sel = ~g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus16.start = 0; bus16.abort = 0; bus16.gate_sel = 0;
    bus12.start = 0; bus12.abort = 0; bus12.gate_sel = 0;
    tap_half = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ro_en16, ro_rst_n16, bus16.busy, bus16.done, bus16.overflow} !== 5'b00000 ||
        bus16.result !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: en/rstn/busy/done/ovf=%b result=%0d, need 00000 and 0",
               {ro_en16, ro_rst_n16, bus16.busy, bus16.done, bus16.overflow}, bus16.result);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if ({ro_en16, ro_rst_n16, bus16.busy, bus16.done} !== 4'b0100 || bus16.result !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: en/rstn/busy/done=%b result=%0d, need 0100 and 0",
               {ro_en16, ro_rst_n16, bus16.busy, bus16.done}, bus16.result);
    end
  endtask

  task automatic test_basic();
    int n, rl, eh;
    logic busy0;
    exp_t e;
    tap_half = 4;
    repeat (20) @(posedge clk);
    sbq.push_back('{lo: 7, hi: 9, ovf: 1'b0});
    launch16(4'd6);
    @(negedge clk);
    n = 0; rl = 0; eh = 0; busy0 = bus16.busy;
    while (n < 400) begin
      if (!ro_rst_n16) rl++;
      if (ro_en16) eh++;
      if (bus16.done) break;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 77) begin
      tests_failed++;
      $display("FAIL basic_latency: done after %0d cycles, need 77", n);
    end
    tests_run++;
    if (rl !== 2 || eh !== 72) begin
      tests_failed++;
      $display("FAIL basic_pins: rst low %0d en high %0d, need 2 and 72", rl, eh);
    end
    tests_run++;
    if (busy0 !== 1'b1 || bus16.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy: start=%b at_done=%b, need 1 and 0", busy0, bus16.busy);
    end
    if (sbq.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL basic_sb: empty scoreboard");
    end else begin
      e = sbq.pop_front();
      tests_run++;
      if (int'(bus16.result) < e.lo || int'(bus16.result) > e.hi || bus16.overflow !== e.ovf) begin
        tests_failed++;
        $display("FAIL basic_result: result=%0d ovf=%b, need %0d..%0d ovf=%b",
                 bus16.result, bus16.overflow, e.lo, e.hi, e.ovf);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus16.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: done=%b one cycle later, need 0", bus16.done);
    end
  endtask

  task automatic test_zero_tap();
    int n;
    exp_t e;
    tap_half = 0;
    repeat (10) @(posedge clk);
    sbq.push_back('{lo: 0, hi: 0, ovf: 1'b0});
    launch16(4'd4);
    n = 0;
    while (bus16.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200 || sbq.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL zero_done: no done pulse within %0d cycles", n);
    end else begin
      e = sbq.pop_front();
      tests_run++;
      if (int'(bus16.result) != e.lo || bus16.overflow !== e.ovf) begin
        tests_failed++;
        $display("FAIL zero_result: result=%0d ovf=%b, need %0d ovf=%b",
                 bus16.result, bus16.overflow, e.lo, e.ovf);
      end
    end
  endtask

  task automatic test_abort();
    int dones;
    tap_half = 4;
    repeat (10) @(posedge clk);
    launch16(4'd6);
    // gate opens 10 cycles after start is sampled
    repeat (30) @(negedge clk);
    bus16.abort = 1'b1;
    @(negedge clk);
    bus16.abort = 1'b0;
    tests_run++;
    if ({bus16.busy, ro_en16, ro_rst_n16, bus16.done} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL abort_state: busy/en/rstn/done=%b, need 0010",
               {bus16.busy, ro_en16, ro_rst_n16, bus16.done});
    end
    dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus16.done) dones++;
    end
    tests_run++;
    if (dones !== 0 || bus16.result !== 16'd0 || bus16.overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_keep: dones=%0d result=%0d ovf=%b, need 0 0 0",
               dones, bus16.result, bus16.overflow);
    end
    bus16.start = 1'b1;
    bus16.abort = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus16.busy !== 1'b0 || ro_rst_n16 !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_priority: busy=%b rstn=%b, need 0 1", bus16.busy, ro_rst_n16);
    end
    bus16.start = 1'b0;
    bus16.abort = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    exp_t e;
    tap_half = 2;
    repeat (10) @(posedge clk);
    sbq.push_back('{lo: 4095, hi: 4095, ovf: 1'b1});
    @(posedge clk);
    #1 bus12.gate_sel = 4'd15;
    bus12.start = 1'b1;
    @(posedge clk);
    #1 bus12.start = 1'b0;
    @(negedge clk);
    n = 0;
    while (bus12.done !== 1'b1 && n < 34000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== 32781) begin
      tests_failed++;
      $display("FAIL ovf_latency: done after %0d cycles, need 32781", n);
    end
    if (sbq.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL ovf_sb: empty scoreboard");
    end else begin
      e = sbq.pop_front();
      tests_run++;
      if (int'(bus12.result) != e.lo || bus12.overflow !== e.ovf) begin
        tests_failed++;
        $display("FAIL ovf_result: result=%0d ovf=%b, need %0d ovf=%b",
                 bus12.result, bus12.overflow, e.lo, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, extra, rst_lows;
    int period;
    exp_t e;
`ifdef RINGOSC_CONT_MEAS_EN
    period = 8 + 32 + 3;
`else
    period = 2 + 8 + 32 + 2 + 1 + 1;
`endif
    tap_half = 4;
    repeat (10) @(posedge clk);
    repeat (3) sbq.push_back('{lo: 3, hi: 5, ovf: 1'b0});
`ifdef RINGOSC_CONT_MEAS_EN
    sbq.push_back('{lo: 3, hi: 5, ovf: 1'b0});
`endif
    @(posedge clk);
    #1 bus16.gate_sel = 4'd5;
    bus16.start = 1'b1;
    rst_lows = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (k > 0 && !ro_rst_n16) rst_lows++;
      end while (bus16.done !== 1'b1 && n < 200);
      if (k > 0) begin
        tests_run++;
        if (n !== period) begin
          tests_failed++;
          $display("FAIL b2b_period%0d: %0d cycles between done, need %0d", k, n, period);
        end
      end
      if (sbq.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL b2b_sb%0d: empty scoreboard", k);
      end else begin
        e = sbq.pop_front();
        tests_run++;
        if (int'(bus16.result) < e.lo || int'(bus16.result) > e.hi || bus16.overflow !== e.ovf) begin
          tests_failed++;
          $display("FAIL b2b_result%0d: result=%0d ovf=%b, need %0d..%0d ovf=%b",
                   k, bus16.result, bus16.overflow, e.lo, e.hi, e.ovf);
        end
      end
    end
`ifdef RINGOSC_CONT_MEAS_EN
    tests_run++;
    if (rst_lows !== 0) begin
      tests_failed++;
      $display("FAIL b2b_divrst: ro_rst_n low %0d cycles after first DRST, need 0", rst_lows);
    end
`endif
    bus16.start = 1'b0;
    extra = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus16.done) begin
        extra++;
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          tests_run++;
          if (int'(bus16.result) < e.lo || int'(bus16.result) > e.hi) begin
            tests_failed++;
            $display("FAIL b2b_last: result=%0d, need %0d..%0d", bus16.result, e.lo, e.hi);
          end
        end
      end
    end while ((bus16.busy || n < 3) && n < 200);
    tests_run++;
    if (bus16.busy !== 1'b0 || sbq.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_stop: busy=%b pending=%0d extra_done=%0d, need 0 0",
               bus16.busy, sbq.size(), extra);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    tap_half = 0;
    test_reset();
    test_basic();
    test_zero_tap();
    test_abort();
    test_overflow();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
